fetch_stall_sequencer: RTL

//  Executes the stall/flush/bubble commands issued by the hazard detection unit: owns the PC register,
//  the IF/ID pipeline register and the ID/EX control-bundle register. Sits between instruction fetch
//  and decode. Also keeps saturating stall/flush counters and a stall watchdog for debug.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/sat_counter.sv | 22 ++
 rtl/fetch_stall_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the fetch/decode pipeline registers.
// Includes the NOP encoding, the PC step and the empty decode control bundle.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam int          CTRL_W    = 12;

  // An all-zero control bundle is a bubble: it writes nothing and reads nothing in EX.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Event counter with a synchronous clear.
// Once it reaches all-ones it holds that value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stall_sequencer.sv
// Applies the hazard unit's stall, flush and bubble commands to the PC, IF/ID and ID/EX control registers.
// It also keeps saturating debug counters and a sticky stall watchdog.
module fetch_stall_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CTRL_W      = pipeline_pkg::CTRL_W,
  parameter int          CNT_W       = 16,
  parameter int          STALL_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              control,
  input  logic              IF_ID_flush,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] ID_ctrl_in,
  output logic [31:0]       PCResult,
  output logic [31:0]       IF_ID_Instr,
  output logic [31:0]       IF_ID_PCPlus4,
  output logic              IF_ID_valid,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              stall_timeout
);

  import pipeline_pkg::NOP_INSTR;
  import pipeline_pkg::PC_STEP;
  import pipeline_pkg::CTRL_BUBBLE;

  localparam int                RUN_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STALL_LIMIT);
  localparam logic [RUN_W-1:0]  RUN_TRIP = RUN_W'(STALL_LIMIT - 1);

  logic [31:0]      pc_plus4;
  logic             stall_cycle;
  logic [RUN_W-1:0] stall_run;

  assign pc_plus4    = PCResult + PC_STEP;
  assign stall_cycle = !PCWrite && !IF_ID_Write;

  // A redirect seen while PCWrite is low is dropped; ID re-presents it after the stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCResult <= RESET_PC;
    end else if (PCWrite) begin
      if (redirect_valid) begin
        PCResult <= {redirect_target[31:2], 2'b00};
      end else begin
        PCResult <= pc_plus4;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || IF_ID_flush) begin
      IF_ID_Instr   <= NOP_INSTR;
      IF_ID_PCPlus4 <= '0;
      IF_ID_valid   <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_Instr   <= instr_in;
      IF_ID_PCPlus4 <= pc_plus4;
      IF_ID_valid   <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || !control || !IF_ID_valid) begin
      ID_EX_Ctrl <= CTRL_W'(CTRL_BUBBLE);
    end else begin
      ID_EX_Ctrl <= ID_ctrl_in;
    end
  end

  // The run length saturates at the limit so a very long stall cannot wrap it back below the trip point.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_run     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (PCWrite) begin
        stall_run <= '0;
      end else if (stall_cycle && (stall_run != RUN_MAX)) begin
        stall_run <= stall_run + 1'b1;
      end
      if (stall_cycle && (stall_run >= RUN_TRIP)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (stall_cycle),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (IF_ID_flush),
    .count (flush_cnt)
  );

endmodule
